// File: rtl/t01_vga_pkg.sv
// Shared VGA colour definitions for the t01 display path.
// Colours are packed {R,G,B}; BLACK is treated as transparent by the compositor.
package t01_vga_pkg;

    typedef logic [2:0] color_t;

    localparam color_t BLACK   = 3'b000;
    localparam color_t RED     = 3'b100;
    localparam color_t GREEN   = 3'b010;
    localparam color_t BLUE    = 3'b001;
    localparam color_t YELLOW  = 3'b110;
    localparam color_t MAGENTA = 3'b101;
    localparam color_t CYAN    = 3'b011;
    localparam color_t WHITE   = 3'b111;

endpackage

// File: rtl/t01_prio_pick.sv
// Combinational first-set finder: lowest set bit of vis_i wins.
// idx_o = NUM_LAYERS and any_o = 0 when nothing is visible.
module t01_prio_pick
    import t01_vga_pkg::*;
#(
    parameter int NUM_LAYERS = 4
)(
    input  logic [NUM_LAYERS-1:0]           vis_i,
    output logic [$clog2(NUM_LAYERS+1)-1:0] idx_o,
    output logic                            any_o
);

    localparam int SEL_W = $clog2(NUM_LAYERS+1);

    // Scan from lowest priority upward so the last hit is the highest-priority layer.
    always_comb begin
        idx_o = SEL_W'(NUM_LAYERS);
        any_o = 1'b0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (vis_i[k]) begin
                idx_o = SEL_W'(k);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/t01_layer_compositor.sv
// N-layer pixel compositor with a fixed 2-cycle pipeline and per-frame shadowed masks.
// Optional layer blinking is built only when T01_LAYER_BLINK_EN is defined.
module t01_layer_compositor
    import t01_vga_pkg::*;
#(
    parameter int   NUM_LAYERS   = 4,
    parameter int   COLOR_W      = $bits(color_t),
    parameter int   COORD_W      = 10,
    parameter logic SYNC_IDLE    = 1'b1,
    parameter int   BLINK_FRAMES = 30
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_LAYERS*COLOR_W-1:0]    layer_color_i,
    input  logic [NUM_LAYERS-1:0]            layer_en_i,
    input  logic [NUM_LAYERS-1:0]            blink_mask_i,
    input  logic [COLOR_W-1:0]               bg_color_i,
    input  logic [COORD_W-1:0]               x_i,
    input  logic [COORD_W-1:0]               y_i,
    input  logic                             hsync_i,
    input  logic                             vsync_i,
    output logic [COLOR_W-1:0]               color_o,
    output logic                             hsync_o,
    output logic                             vsync_o,
    output logic [COORD_W-1:0]               x_o,
    output logic [COORD_W-1:0]               y_o,
    output logic [$clog2(NUM_LAYERS+1)-1:0]  layer_sel_o,
    output logic                             blink_phase_o
);

    localparam int SEL_W = $clog2(NUM_LAYERS+1);

    if (NUM_LAYERS < 2 || NUM_LAYERS > 8) begin : g_bad_layers
        $error("t01_layer_compositor: NUM_LAYERS must be 2..8");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("t01_layer_compositor: BLINK_FRAMES must be >= 1");
    end

    logic                          vsync_prev_q, vsync_prev_d;
    logic                          frame_start;
    logic [NUM_LAYERS-1:0]         en_shadow_q, en_shadow_d;
    logic [NUM_LAYERS-1:0]         hide;

    logic [NUM_LAYERS*COLOR_W-1:0] col_s1_q, col_s1_d;
    logic [COLOR_W-1:0]            bg_s1_q, bg_s1_d;
    logic [COORD_W-1:0]            x_s1_q, x_s1_d, y_s1_q, y_s1_d;
    logic                          hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
    logic [NUM_LAYERS-1:0]         vis_s1_q, vis_s1_d;

    logic [COLOR_W-1:0]            color_q, color_d;
    logic [SEL_W-1:0]              sel_q, sel_d;
    logic [COORD_W-1:0]            x_q, x_d, y_q, y_d;
    logic                          hs_q, hs_d, vs_q, vs_d;

    logic [SEL_W-1:0]              pick_idx;
    logic                          pick_any;

    assign frame_start = (vsync_i != SYNC_IDLE) && (vsync_prev_q == SYNC_IDLE);

    always_comb begin
        vsync_prev_d = vsync_i;
        en_shadow_d  = frame_start ? layer_en_i : en_shadow_q;
    end

`ifdef T01_LAYER_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

    logic [NUM_LAYERS-1:0] blink_shadow_q, blink_shadow_d;
    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic                  blink_phase_q, blink_phase_d;

    always_comb begin
        blink_shadow_d = blink_shadow_q;
        frame_cnt_d    = frame_cnt_q;
        blink_phase_d  = blink_phase_q;
        if (frame_start) begin
            blink_shadow_d = blink_mask_i;
            if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_shadow_q <= '0;
            frame_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
        end else begin
            blink_shadow_q <= blink_shadow_d;
            frame_cnt_q    <= frame_cnt_d;
            blink_phase_q  <= blink_phase_d;
        end
    end

    assign hide          = blink_shadow_q & {NUM_LAYERS{blink_phase_q}};
    assign blink_phase_o = blink_phase_q;
`else
    logic unused_blink_mask;

    assign unused_blink_mask = ^blink_mask_i;
    assign hide              = '0;
    assign blink_phase_o     = 1'b0;
`endif

    // S1 uses the shadows as they stand this cycle; a frame_start cycle still sees the old ones.
    always_comb begin
        col_s1_d = layer_color_i;
        bg_s1_d  = bg_color_i;
        x_s1_d   = x_i;
        y_s1_d   = y_i;
        hs_s1_d  = hsync_i;
        vs_s1_d  = vsync_i;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            vis_s1_d[k] = en_shadow_q[k] & (|layer_color_i[k*COLOR_W +: COLOR_W]) & ~hide[k];
        end
    end

    t01_prio_pick #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_prio_pick (
        .vis_i (vis_s1_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        color_d = bg_s1_q;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (pick_any && pick_idx == SEL_W'(k)) begin
                color_d = col_s1_q[k*COLOR_W +: COLOR_W];
            end
        end
        sel_d = pick_idx;
        x_d   = x_s1_q;
        y_d   = y_s1_q;
        hs_d  = hs_s1_q;
        vs_d  = vs_s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_prev_q <= SYNC_IDLE;
            en_shadow_q  <= '1;
            col_s1_q     <= '0;
            bg_s1_q      <= '0;
            x_s1_q       <= '0;
            y_s1_q       <= '0;
            hs_s1_q      <= SYNC_IDLE;
            vs_s1_q      <= SYNC_IDLE;
            vis_s1_q     <= '0;
            color_q      <= '0;
            sel_q        <= SEL_W'(NUM_LAYERS);
            x_q          <= '0;
            y_q          <= '0;
            hs_q         <= SYNC_IDLE;
            vs_q         <= SYNC_IDLE;
        end else begin
            vsync_prev_q <= vsync_prev_d;
            en_shadow_q  <= en_shadow_d;
            col_s1_q     <= col_s1_d;
            bg_s1_q      <= bg_s1_d;
            x_s1_q       <= x_s1_d;
            y_s1_q       <= y_s1_d;
            hs_s1_q      <= hs_s1_d;
            vs_s1_q      <= vs_s1_d;
            vis_s1_q     <= vis_s1_d;
            color_q      <= color_d;
            sel_q        <= sel_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
        end
    end

    assign color_o     = color_q;
    assign layer_sel_o = sel_q;
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign hsync_o     = hs_q;
    assign vsync_o     = vs_q;

endmodule

// File: tb/tb_t01_layer_compositor.sv
// Scoreboard bench for t01_layer_compositor: stimulus pushes expected pixels, a monitor
// compares them 2 cycles later. Blink expectations follow T01_LAYER_BLINK_EN.
module tb_t01_layer_compositor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] layer_color_i = '0;
    logic [3:0]  layer_en_i = 4'b1111;
    logic [3:0]  blink_mask_i = 4'b0000;
    logic [2:0]  bg_color_i = '0;
    logic [9:0]  x_i = '0;
    logic [9:0]  y_i = '0;
    logic        hsync_i = 1'b1;
    logic        vsync_i = 1'b1;
    logic [2:0]  color_o;
    logic        hsync_o, vsync_o;
    logic [9:0]  x_o, y_o;
    logic [2:0]  layer_sel_o;
    logic        blink_phase_o;

    t01_layer_compositor #(
        .BLINK_FRAMES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .layer_color_i (layer_color_i),
        .layer_en_i    (layer_en_i),
        .blink_mask_i  (blink_mask_i),
        .bg_color_i    (bg_color_i),
        .x_i           (x_i),
        .y_i           (y_i),
        .hsync_i       (hsync_i),
        .vsync_i       (vsync_i),
        .color_o       (color_o),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .x_o           (x_o),
        .y_o           (y_o),
        .layer_sel_o   (layer_sel_o),
        .blink_phase_o (blink_phase_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        bit         chk;
        string      name;
        logic [2:0] color;
        logic [2:0] sel;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.chk) begin
                n_tests++;
                if (color_o !== e.color || layer_sel_o !== e.sel || x_o !== e.x ||
                    y_o !== e.y || hsync_o !== e.hs || vsync_o !== e.vs) begin
                    n_fail++;
                    $display("FAIL %s: got color=%b sel=%0d x=%0d y=%0d hs=%b vs=%b, expected color=%b sel=%0d x=%0d y=%0d hs=%b vs=%b",
                             e.name, color_o, layer_sel_o, x_o, y_o, hsync_o, vsync_o,
                             e.color, e.sel, e.x, e.y, e.hs, e.vs);
                end
            end
        end
    end

    task automatic pix(input string nm, input logic [11:0] cols, input logic [2:0] bg,
                       input logic [9:0] x, input logic [9:0] y, input logic hs, input logic vs,
                       input bit chk, input logic [2:0] ec, input logic [2:0] es);
        exp_t e;
        @(negedge clk);
        layer_color_i = cols;
        bg_color_i    = bg;
        x_i           = x;
        y_i           = y;
        hsync_i       = hs;
        vsync_i       = vs;
        e.due   = cyc + 2;
        e.chk   = chk;
        e.name  = nm;
        e.color = ec;
        e.sel   = es;
        e.x     = x;
        e.y     = y;
        e.hs    = hs;
        e.vs    = vs;
        q.push_back(e);
    endtask

    task automatic chk_val(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // One-cycle vsync pulse, then check the blink phase that the frame start produced.
    task automatic frame_edge(input string nm, input logic [11:0] cols, input logic exp_phase);
        pix(nm, cols, 3'b000, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 3'b000, 3'd0);
        pix(nm, cols, 3'b000, 10'd1, 10'd0, 1'b1, 1'b1, 1'b0, 3'b000, 3'd0);
        chk_val({nm, "_phase"}, {15'd0, blink_phase_o}, {15'd0, exp_phase});
    endtask

    localparam logic [11:0] L0_RED   = 12'b000_000_000_100;
    localparam logic [11:0] L0_MAG   = 12'b000_000_000_101;
    localparam logic [11:0] L12      = 12'b000_001_010_000;
    localparam logic [11:0] L3_YEL   = 12'b110_000_000_000;
    localparam logic [11:0] BLINKPAT = 12'b000_000_011_101;

    initial begin
        logic ph [0:4];
        bit   blink_on;
`ifdef T01_LAYER_BLINK_EN
        blink_on = 1'b1;
`else
        blink_on = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Run some traffic, then reset asynchronously mid-cycle.
        pix("pre_rst_a", L0_MAG, 3'b000, 10'd10, 10'd5, 1'b1, 1'b1, 1'b1, 3'b101, 3'd0);
        pix("pre_rst_b", L0_MAG, 3'b000, 10'd11, 10'd5, 1'b1, 1'b1, 1'b1, 3'b101, 3'd0);
        pix("pre_rst_c", L0_MAG, 3'b000, 10'd12, 10'd5, 1'b0, 1'b0, 1'b0, 3'b101, 3'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk_val("rst_color", {13'd0, color_o}, 16'd0);
        chk_val("rst_sel", {13'd0, layer_sel_o}, 16'd4);
        chk_val("rst_syncs", {14'd0, hsync_o, vsync_o}, 16'd3);
        chk_val("rst_xy", {x_o[7:0], y_o[7:0]}, 16'd0);
        chk_val("rst_phase", {15'd0, blink_phase_o}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        pix("rel_l0", L0_RED, 3'b000, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 3'b100, 3'd0);
        pix("rel_next", 12'd0, 3'b000, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 3'b000, 3'd4);

        // Priority and background.
        pix("prio_l1", L12, 3'b000, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 3'b010, 3'd1);
        pix("prio_bg", 12'd0, 3'b111, 10'd3, 10'd0, 1'b1, 1'b1, 1'b1, 3'b111, 3'd4);
        pix("prio_l3", L3_YEL, 3'b001, 10'd4, 10'd0, 1'b1, 1'b1, 1'b1, 3'b110, 3'd3);
        pix("prio_l0", L0_RED | L12, 3'b111, 10'd5, 10'd1, 1'b1, 1'b1, 1'b1, 3'b100, 3'd0);

        // Sync/coordinate alignment.
        pix("hs_654", L0_RED, 3'b000, 10'd654, 10'd7, 1'b1, 1'b1, 1'b1, 3'b100, 3'd0);
        pix("hs_655", L0_RED, 3'b000, 10'd655, 10'd7, 1'b0, 1'b1, 1'b1, 3'b100, 3'd0);
        pix("hs_656", L0_RED, 3'b000, 10'd656, 10'd7, 1'b1, 1'b1, 1'b1, 3'b100, 3'd0);

        // Enable shadowing: change takes effect only after the next frame start.
        pix("en_before", L12, 3'b000, 10'd20, 10'd9, 1'b1, 1'b1, 1'b1, 3'b010, 3'd1);
        layer_en_i = 4'b1101;
        pix("en_midframe", L12, 3'b000, 10'd21, 10'd9, 1'b1, 1'b1, 1'b1, 3'b010, 3'd1);
        pix("en_fs_cycle", L12, 3'b000, 10'd22, 10'd9, 1'b1, 1'b0, 1'b1, 3'b010, 3'd1);
        pix("en_after", L12, 3'b000, 10'd23, 10'd0, 1'b1, 1'b1, 1'b1, 3'b001, 3'd2);
        pix("en_after2", L12, 3'b000, 10'd24, 10'd0, 1'b1, 1'b1, 1'b1, 3'b001, 3'd2);

        // Blink: clean reset so the frame counter starts from zero.
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        layer_en_i   = 4'b1111;
        blink_mask_i = 4'b0001;
        ph[0] = 1'b0;
        ph[1] = 1'b0;
        ph[2] = blink_on;
        ph[3] = blink_on;
        ph[4] = 1'b0;
        for (int f = 0; f < 5; f++) begin
            string nm;
            nm = $sformatf("blink_f%0d", f);
            if (f > 0) frame_edge({nm, "_edge"}, BLINKPAT, ph[f]);
            if (ph[f])
                pix(nm, BLINKPAT, 3'b000, 10'd30, 10'd2, 1'b1, 1'b1, 1'b1, 3'b011, 3'd1);
            else
                pix(nm, BLINKPAT, 3'b000, 10'd30, 10'd2, 1'b1, 1'b1, 1'b1, 3'b101, 3'd0);
        end

        repeat (4) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected outputs never compared, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
